// File: rtl/mfb_eth_port_merge_pkg.sv
// Shared types and width helpers for the Ethernet-port MFB merger.
package mfb_eth_port_merge_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } merge_state_t;

  // ceil(log2(n)), never below 1 so that single-port or single-item builds keep real vectors
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned mfb_data_width(input int unsigned region_size,
                                                 input int unsigned block_size,
                                                 input int unsigned item_width);
    return region_size * block_size * item_width;
  endfunction

endpackage

// File: rtl/mfb_eth_port_merge_arb.sv
// Round-robin selector: first requester at or after ptr, wrapping, as a one-hot grant.
module rr_arbiter #(
  parameter int unsigned PORTS = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PORTS-1:0] grant
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      idx = (32'(ptr) + k) % PORTS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mfb_eth_port_merge.sv
// Merges PORTS MFB streams into one at packet granularity with a single output register stage.
module mfb_eth_port_merge
  import mfb_eth_port_merge_pkg::*;
#(
  parameter int unsigned PORTS       = 2,
  parameter int unsigned REGION_SIZE = 8,
  parameter int unsigned BLOCK_SIZE  = 8,
  parameter int unsigned ITEM_WIDTH  = 8,
  parameter int unsigned META_WIDTH  = 24,
  parameter string       DEVICE      = "AGILEX",
  localparam int unsigned DW  = mfb_data_width(REGION_SIZE, BLOCK_SIZE, ITEM_WIDTH),
  localparam int unsigned SPW = clog2_min1(REGION_SIZE),
  localparam int unsigned EPW = clog2_min1(REGION_SIZE * BLOCK_SIZE),
  localparam int unsigned IDW = clog2_min1(PORTS)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [PORTS*DW-1:0]         RX_MFB_DATA,
  input  logic [PORTS*META_WIDTH-1:0] RX_MFB_META,
  input  logic [PORTS-1:0]            RX_MFB_SOF,
  input  logic [PORTS-1:0]            RX_MFB_EOF,
  input  logic [PORTS*SPW-1:0]        RX_MFB_SOF_POS,
  input  logic [PORTS*EPW-1:0]        RX_MFB_EOF_POS,
  input  logic [PORTS-1:0]            RX_MFB_SRC_RDY,
  output logic [PORTS-1:0]            RX_MFB_DST_RDY,
  output logic [DW-1:0]               TX_MFB_DATA,
  output logic [IDW+META_WIDTH-1:0]   TX_MFB_META,
  output logic                        TX_MFB_SOF,
  output logic                        TX_MFB_EOF,
  output logic [SPW-1:0]              TX_MFB_SOF_POS,
  output logic [EPW-1:0]              TX_MFB_EOF_POS,
  output logic                        TX_MFB_SRC_RDY,
  input  logic                        TX_MFB_DST_RDY
);

  merge_state_t          state;
  logic [IDW-1:0]        lock_port;
  logic [IDW-1:0]        rr;
  logic [IDW-1:0]        grant_idx;
  logic [IDW-1:0]        sel_port;
  logic [PORTS-1:0]      grant;
  logic                  out_ready;
  logic                  sel_valid;
  logic                  xfer;
  logic                  stays_open;
  logic [DW-1:0]         sel_data;
  logic [META_WIDTH-1:0] sel_meta;
  logic                  sel_sof;
  logic                  sel_eof;
  logic [SPW-1:0]        sel_sof_pos;
  logic [EPW-1:0]        sel_eof_pos;

  logic [DW-1:0]             tx_data;
  logic [IDW+META_WIDTH-1:0] tx_meta;
  logic                      tx_sof;
  logic                      tx_eof;
  logic [SPW-1:0]            tx_sof_pos;
  logic [EPW-1:0]            tx_eof_pos;
  logic                      tx_src_rdy;

  rr_arbiter #(
    .PORTS(PORTS),
    .PTR_W(IDW)
  ) u_rr_arbiter (
    .req  (RX_MFB_SRC_RDY),
    .ptr  (rr),
    .grant(grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (grant[i]) grant_idx = IDW'(i);
    end
  end

  assign sel_port  = (state == ST_LOCKED) ? lock_port : grant_idx;
  assign out_ready = !tx_src_rdy || TX_MFB_DST_RDY;

  always_comb begin
    sel_valid   = 1'b0;
    sel_data    = '0;
    sel_meta    = '0;
    sel_sof     = 1'b0;
    sel_eof     = 1'b0;
    sel_sof_pos = '0;
    sel_eof_pos = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (IDW'(i) == sel_port) begin
        sel_valid   = RX_MFB_SRC_RDY[i];
        sel_data    = RX_MFB_DATA[i*DW +: DW];
        sel_meta    = RX_MFB_META[i*META_WIDTH +: META_WIDTH];
        sel_sof     = RX_MFB_SOF[i];
        sel_eof     = RX_MFB_EOF[i];
        sel_sof_pos = RX_MFB_SOF_POS[i*SPW +: SPW];
        sel_eof_pos = RX_MFB_EOF_POS[i*EPW +: EPW];
      end
    end
  end

  assign xfer = sel_valid && out_ready && !RESET;

  always_comb begin
    RX_MFB_DST_RDY = '0;
    if (!RESET && out_ready && (state == ST_LOCKED || |grant)) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (IDW'(i) == sel_port) RX_MFB_DST_RDY[i] = 1'b1;
      end
    end
  end

  // A word carrying EOF and a later SOF closes one packet and opens the next one on the same port
  always_comb begin
    stays_open = (sel_sof && !sel_eof)
              || (sel_sof && sel_eof && (32'(sel_sof_pos) * BLOCK_SIZE > 32'(sel_eof_pos)))
              || (!sel_sof && !sel_eof && state == ST_LOCKED);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      lock_port  <= '0;
      rr         <= '0;
      tx_src_rdy <= 1'b0;
    end else begin
      if (xfer) begin
        tx_src_rdy <= 1'b1;
        state      <= stays_open ? ST_LOCKED : ST_IDLE;
        lock_port  <= sel_port;
        if (state == ST_IDLE) begin
          rr <= (sel_port == IDW'(PORTS - 1)) ? '0 : sel_port + IDW'(1);
        end
      end else if (TX_MFB_DST_RDY) begin
        tx_src_rdy <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (xfer) begin
      tx_data    <= sel_data;
      tx_meta    <= {sel_port, sel_meta};
      tx_sof     <= sel_sof;
      tx_eof     <= sel_eof;
      tx_sof_pos <= sel_sof_pos;
      tx_eof_pos <= sel_eof_pos;
    end
  end

  assign TX_MFB_DATA    = tx_data;
  assign TX_MFB_META    = tx_meta;
  assign TX_MFB_SOF     = tx_sof;
  assign TX_MFB_EOF     = tx_eof;
  assign TX_MFB_SOF_POS = tx_sof_pos;
  assign TX_MFB_EOF_POS = tx_eof_pos;
  assign TX_MFB_SRC_RDY = tx_src_rdy;

endmodule

// File: tb/tb_mfb_eth_port_merge.sv
// Randomized self-checking bench for mfb_eth_port_merge with a per-port packet scoreboard.
module tb_mfb_eth_port_merge;

  localparam int P   = 4;
  localparam int RS  = 8;
  localparam int BS  = 8;
  localparam int IW  = 8;
  localparam int MW  = 24;
  localparam int DW  = RS * BS * IW;
  localparam int SPW = 3;
  localparam int EPW = 6;
  localparam int IDW = 2;
  localparam int SVW = DW + MW + IDW + 2 + SPW + EPW;

  typedef struct {
    logic [DW-1:0]  data;
    logic [MW-1:0]  meta;
    logic           sof;
    logic           eof;
    logic [SPW-1:0] sof_pos;
    logic [EPW-1:0] eof_pos;
  } word_t;

  logic              clk;
  logic              rst = 1'b1;
  logic [P*DW-1:0]   rx_data = '0;
  logic [P*MW-1:0]   rx_meta = '0;
  logic [P-1:0]      rx_sof = '0;
  logic [P-1:0]      rx_eof = '0;
  logic [P*SPW-1:0]  rx_sof_pos = '0;
  logic [P*EPW-1:0]  rx_eof_pos = '0;
  logic [P-1:0]      rx_src_rdy = '0;
  logic [P-1:0]      rx_dst_rdy;
  logic [DW-1:0]     tx_data;
  logic [IDW+MW-1:0] tx_meta;
  logic              tx_sof;
  logic              tx_eof;
  logic [SPW-1:0]    tx_sof_pos;
  logic [EPW-1:0]    tx_eof_pos;
  logic              tx_src_rdy;
  logic              tx_dst_rdy = 1'b1;

  mfb_eth_port_merge #(
    .PORTS(P), .REGION_SIZE(RS), .BLOCK_SIZE(BS), .ITEM_WIDTH(IW),
    .META_WIDTH(MW), .DEVICE("AGILEX")
  ) dut (
    .CLK(clk), .RESET(rst),
    .RX_MFB_DATA(rx_data), .RX_MFB_META(rx_meta),
    .RX_MFB_SOF(rx_sof), .RX_MFB_EOF(rx_eof),
    .RX_MFB_SOF_POS(rx_sof_pos), .RX_MFB_EOF_POS(rx_eof_pos),
    .RX_MFB_SRC_RDY(rx_src_rdy), .RX_MFB_DST_RDY(rx_dst_rdy),
    .TX_MFB_DATA(tx_data), .TX_MFB_META(tx_meta),
    .TX_MFB_SOF(tx_sof), .TX_MFB_EOF(tx_eof),
    .TX_MFB_SOF_POS(tx_sof_pos), .TX_MFB_EOF_POS(tx_eof_pos),
    .TX_MFB_SRC_RDY(tx_src_rdy), .TX_MFB_DST_RDY(tx_dst_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  word_t drv_q[P][$];
  word_t exp_q[P][$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  logic  rst_next = 1'b1;
  int    tx_rdy_mode = 0;
  int    tx_rdy_pat[$];
  int    tx_port_log[$];
  int    tx_cyc_log[$];
  int    sof_port_log[$];
  int    rx_port_log[$];
  int    open_port = -1;
  int    prev_hs_port = -1;
  bit    prev_stall = 0;
  logic [SVW-1:0] saved_tx;

  function automatic word_t make_word(input logic sof, input logic eof,
                                      input int sof_pos, input int eof_pos);
    word_t w;
    for (int k = 0; k < DW / 32; k++) w.data[k*32 +: 32] = $urandom();
    w.meta    = MW'($urandom());
    w.sof     = sof;
    w.eof     = eof;
    w.sof_pos = SPW'(sof_pos);
    w.eof_pos = EPW'(eof_pos);
    return w;
  endfunction

  task automatic push_packet(input int p, input int len);
    for (int k = 0; k < len; k++) begin
      drv_q[p].push_back(make_word(k == 0, k == len - 1, 0, $urandom_range(63)));
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < P; i++) begin
      if (drv_q[i].size() != 0 || exp_q[i].size() != 0) return 0;
    end
    return 1;
  endfunction

  task automatic clear_logs();
    tx_port_log.delete();
    tx_cyc_log.delete();
    sof_port_log.delete();
    rx_port_log.delete();
  endtask

  task automatic clear_state();
    for (int i = 0; i < P; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
    clear_logs();
    tx_rdy_pat.delete();
    tx_rdy_mode  = 0;
    open_port    = -1;
    prev_hs_port = -1;
    prev_stall   = 0;
  endtask

  // One clock: drive at negedge, sample just after, account handshakes taken at the next posedge
  task automatic cycle();
    word_t      w;
    int         p;
    int         hs_port;
    logic [P-1:0] hs;
    @(negedge clk);
    rst = rst_next;
    for (int i = 0; i < P; i++) begin
      if (drv_q[i].size() > 0) begin
        w = drv_q[i][0];
        rx_src_rdy[i] = 1'b1;
        rx_data[i*DW +: DW]       = w.data;
        rx_meta[i*MW +: MW]       = w.meta;
        rx_sof[i]                 = w.sof;
        rx_eof[i]                 = w.eof;
        rx_sof_pos[i*SPW +: SPW]  = w.sof_pos;
        rx_eof_pos[i*EPW +: EPW]  = w.eof_pos;
      end else begin
        rx_src_rdy[i] = 1'b0;
        rx_sof[i]     = 1'b0;
        rx_eof[i]     = 1'b0;
      end
    end
    if (tx_rdy_pat.size() > 0) tx_dst_rdy = (tx_rdy_pat.pop_front() != 0);
    else if (tx_rdy_mode == 1) tx_dst_rdy = ($urandom_range(3) != 0);
    else tx_dst_rdy = 1'b1;
    #1;
    cyc++;
    hs = rx_src_rdy & rx_dst_rdy;

    if (rst) begin
      checks++;
      if (rx_dst_rdy !== '0) begin
        failures++;
        $display("FAIL reset_rx_dst_rdy: got %b, required 0000", rx_dst_rdy);
      end
    end else begin
      checks++;
      if ($countones(rx_dst_rdy) > 1 || $isunknown(rx_dst_rdy)) begin
        failures++;
        $display("FAIL onehot_rx_dst_rdy: got %b, required at most one bit set", rx_dst_rdy);
      end
      if (prev_stall) begin
        checks++;
        if ({tx_data, tx_meta, tx_sof, tx_eof, tx_sof_pos, tx_eof_pos} !== saved_tx || tx_src_rdy !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold: TX changed while stalled (src_rdy=%b meta=%h, required meta=%h)",
                   tx_src_rdy, tx_meta, saved_tx[SVW-DW-1 -: IDW+MW]);
        end
      end
      if (prev_hs_port >= 0) begin
        checks++;
        if (tx_src_rdy !== 1'b1 || int'(tx_meta[MW+IDW-1 -: IDW]) != prev_hs_port) begin
          failures++;
          $display("FAIL latency: got src_rdy=%b id=%0d, required src_rdy=1 id=%0d",
                   tx_src_rdy, tx_meta[MW+IDW-1 -: IDW], prev_hs_port);
        end
      end
      if (tx_src_rdy === 1'b1 && tx_dst_rdy === 1'b0) begin
        checks++;
        if (rx_dst_rdy !== '0) begin
          failures++;
          $display("FAIL stall_rx_dst_rdy: got %b, required 0000", rx_dst_rdy);
        end
      end
    end

    if (tx_src_rdy === 1'b1 && tx_dst_rdy === 1'b1) begin
      p = int'(tx_meta[MW+IDW-1 -: IDW]);
      tx_port_log.push_back(p);
      tx_cyc_log.push_back(cyc);
      checks++;
      if (open_port >= 0 && p != open_port) begin
        failures++;
        $display("FAIL interleave: got word from port %0d, required port %0d", p, open_port);
      end
      if (open_port < 0 && tx_sof === 1'b1) sof_port_log.push_back(p);
      checks++;
      if (exp_q[p].size() == 0) begin
        failures++;
        $display("FAIL scoreboard_extra: got unexpected word from port %0d, required none", p);
      end else begin
        w = exp_q[p].pop_front();
        if (tx_data !== w.data || tx_sof !== w.sof || tx_eof !== w.eof ||
            tx_sof_pos !== w.sof_pos || tx_eof_pos !== w.eof_pos ||
            (w.sof && tx_meta[MW-1:0] !== w.meta)) begin
          failures++;
          $display("FAIL scoreboard port%0d: got sof=%b eof=%b sp=%0d ep=%0d d=%h m=%h, required sof=%b eof=%b sp=%0d ep=%0d d=%h m=%h",
                   p, tx_sof, tx_eof, tx_sof_pos, tx_eof_pos, tx_data[31:0], tx_meta[MW-1:0],
                   w.sof, w.eof, w.sof_pos, w.eof_pos, w.data[31:0], w.meta);
        end
      end
      if (tx_sof && !tx_eof) open_port = p;
      else if (tx_sof && tx_eof && int'(tx_sof_pos) * BS > int'(tx_eof_pos)) open_port = p;
      else if (!tx_sof && !tx_eof && open_port >= 0) open_port = open_port;
      else open_port = -1;
    end

    hs_port = -1;
    for (int i = 0; i < P; i++) begin
      if (hs[i] === 1'b1) begin
        hs_port = i;
        w = drv_q[i].pop_front();
        exp_q[i].push_back(w);
        rx_port_log.push_back(i);
      end
    end
    prev_hs_port = rst ? -1 : hs_port;
    prev_stall   = !rst && tx_src_rdy === 1'b1 && tx_dst_rdy === 1'b0;
    saved_tx     = {tx_data, tx_meta, tx_sof, tx_eof, tx_sof_pos, tx_eof_pos};
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (!all_empty()) begin
      failures++;
      $display("FAIL %s_timeout: traffic still pending after %0d cycles, required drained", name, budget);
    end
  endtask

  task automatic do_reset();
    clear_state();
    rst_next = 1'b1;
    cycle();
    cycle();
    rst_next = 1'b0;
    clear_state();
  endtask

  task automatic check_seq(input string name, input int got[$], input int want[$]);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %p, required %p", name, got, want);
    end
  endtask

  task automatic test_reset();
    clear_state();
    push_packet(1, 1);
    push_packet(0, 1);
    rst_next = 1'b1;
    cycle();
    cycle();
    checks++;
    if (tx_src_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_tx_src_rdy: got %b, required 0", tx_src_rdy);
    end
    cycle();
    checks++;
    if (tx_src_rdy !== 1'b0 || rx_dst_rdy !== '0) begin
      failures++;
      $display("FAIL reset_hold: got src_rdy=%b dst_rdy=%b, required 0 and 0000", tx_src_rdy, rx_dst_rdy);
    end
    rst_next = 1'b0;
    drain(50, "reset");
    check_seq("reset_first_grant", sof_port_log, '{0, 1});
  endtask

  task automatic test_alternate();
    int want[$];
    int got_gap[$];
    int want_gap[$];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_packet(0, 1);
      push_packet(1, 1);
      want.push_back(0);
      want.push_back(1);
    end
    drain(100, "alternate");
    check_seq("alternate_ids", tx_port_log, want);
    for (int k = 1; k < tx_cyc_log.size(); k++) begin
      got_gap.push_back(tx_cyc_log[k] - tx_cyc_log[k-1]);
      want_gap.push_back(1);
    end
    check_seq("alternate_one_per_cycle", got_gap, want_gap);
  endtask

  task automatic test_locked();
    do_reset();
    push_packet(0, 3);
    cycle();
    push_packet(1, 1);
    drain(100, "locked");
    check_seq("locked_rx_order", rx_port_log, '{0, 0, 0, 1});
    check_seq("locked_tx_order", tx_port_log, '{0, 0, 0, 1});
  endtask

  task automatic test_sof_after_eof();
    do_reset();
    drv_q[0].push_back(make_word(1'b1, 1'b0, 0, 0));
    drv_q[0].push_back(make_word(1'b1, 1'b1, 2, 10));
    drv_q[0].push_back(make_word(1'b0, 1'b1, 0, 20));
    push_packet(1, 1);
    drain(100, "sof_after_eof");
    check_seq("sof_after_eof_order", tx_port_log, '{0, 0, 0, 1});
    check_seq("sof_after_eof_grants", sof_port_log, '{0, 1});
  endtask

  task automatic test_stall();
    do_reset();
    push_packet(0, 4);
    tx_rdy_pat = '{1, 0, 0, 1};
    drain(100, "stall");
    check_seq("stall_tx_words", tx_port_log, '{0, 0, 0, 0});
    check_seq("stall_rx_words", rx_port_log, '{0, 0, 0, 0});
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    push_packet(0, 4);
    push_packet(1, 1);
    n = 0;
    while (rx_port_log.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (rx_port_log.size() < 2) begin
      failures++;
      $display("FAIL reset_mid_words: got %0d accepted, required 2", rx_port_log.size());
    end
    rst_next = 1'b1;
    cycle();
    rst_next = 1'b0;
    drv_q[0].delete();
    open_port = -1;
    push_packet(0, 1);
    clear_logs();
    cycle();
    checks++;
    if (tx_src_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_tx_src_rdy: got %b, required 0", tx_src_rdy);
    end
    drain(100, "reset_mid");
    check_seq("reset_mid_grants", sof_port_log, '{0, 1});
  endtask

  task automatic test_random();
    int want[$];
    int total;
    int len;
    do_reset();
    total = 0;
    for (int k = 0; k < 100; k++) begin
      len = $urandom_range(1, 4);
      push_packet(k % P, len);
      total += len;
      want.push_back(k % P);
    end
    tx_rdy_mode = 1;
    drain(5000, "random");
    tx_rdy_mode = 0;
    check_seq("random_grant_cycle", sof_port_log, want);
    checks++;
    if (tx_port_log.size() != total) begin
      failures++;
      $display("FAIL random_word_count: got %0d, required %0d", tx_port_log.size(), total);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alternate();
    test_locked();
    test_sof_after_eof();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
